// File: rtl/rsa_seq.sv
// Operand sequencer and result controller in front of rsa_core: streams P, Q, E, M to the core
// as single-cycle load strobes, supervises the computation and hands back the result.
module rsa_seq #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_OPERANDS = 4,
    parameter int unsigned TIMEOUT      = 4096,
    parameter bit          CLK_EDGE     = 1'b1
) (
    input  logic                  seq_clk,
    input  logic                  seq_rst,
    input  logic                  seq_abort,
    input  logic                  seq_in_valid,
    input  logic [DATA_WIDTH-1:0] seq_in_data,
    output logic                  seq_in_ready,
    output logic                  seq_core_load,
    output logic [DATA_WIDTH-1:0] seq_core_din,
    input  logic                  seq_core_done,
    input  logic                  seq_core_err,
    input  logic [DATA_WIDTH-1:0] seq_core_dout,
    output logic                  seq_out_valid,
    output logic [DATA_WIDTH-1:0] seq_out_data,
    input  logic                  seq_out_ready,
    output logic                  seq_busy,
    output logic                  seq_err,
    output logic [1:0]            seq_err_code
);

    localparam int unsigned CntW = $clog2(NUM_OPERANDS + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT);

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrCore     = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;
    localparam logic [1:0] ErrSpurious = 2'b11;

    typedef enum logic [2:0] {
        StAccept,
        StPulse,
        StWait,
        StOut,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [TmrW-1:0]       timer_q, timer_d;
    logic                  done_q;
    logic                  load_q, load_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  done_rise;

    // Falling-edge operation is obtained by inverting the clock ahead of every flop.
    logic clk_g;
    assign clk_g = CLK_EDGE ? seq_clk : ~seq_clk;

    assign done_rise = seq_core_done & ~done_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        timer_d     = timer_q;
        load_d      = 1'b0;
        din_d       = din_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_code_d  = err_code_q;

        if (seq_abort) begin
            state_d     = StAccept;
            count_d     = '0;
            timer_d     = '0;
            out_valid_d = 1'b0;
            err_code_d  = ErrNone;
        end else if (seq_core_err && state_q != StErr) begin
            state_d     = StErr;
            err_code_d  = ErrCore;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                StAccept: begin
                    if (done_rise) begin
                        state_d    = StErr;
                        err_code_d = ErrSpurious;
                    end else if (seq_in_valid) begin
                        din_d   = seq_in_data;
                        load_d  = 1'b1;
                        count_d = count_q + CntW'(1);
                        state_d = StPulse;
                    end
                end
                StPulse: begin
                    if (done_rise) begin
                        state_d    = StErr;
                        err_code_d = ErrSpurious;
                    end else if (count_q == CntW'(NUM_OPERANDS)) begin
                        state_d = StWait;
                        timer_d = '0;
                    end else begin
                        state_d = StAccept;
                    end
                end
                StWait: begin
                    timer_d = timer_q + TmrW'(1);
                    // Timeout outranks a done arriving on the very last allowed cycle.
                    if (timer_q == TmrW'(TIMEOUT - 1)) begin
                        state_d    = StErr;
                        err_code_d = ErrTimeout;
                    end else if (done_rise) begin
                        out_data_d  = seq_core_dout;
                        out_valid_d = 1'b1;
                        state_d     = StOut;
                    end
                end
                StOut: begin
                    if (seq_out_ready) begin
                        out_valid_d = 1'b0;
                        count_d     = '0;
                        state_d     = StAccept;
                    end
                end
                StErr: begin
                    out_valid_d = 1'b0;
                end
                default: begin
                    state_d = StAccept;
                end
            endcase
        end
    end

    always_ff @(posedge clk_g or negedge seq_rst) begin
        if (!seq_rst) begin
            state_q     <= StAccept;
            count_q     <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            load_q      <= 1'b0;
            din_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_code_q  <= ErrNone;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            done_q      <= seq_core_done;
            load_q      <= load_d;
            din_q       <= din_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_code_q  <= err_code_d;
        end
    end

    assign seq_in_ready  = (state_q == StAccept);
    assign seq_busy      = (state_q != StAccept) || (count_q != '0);
    assign seq_core_load = load_q;
    assign seq_core_din  = din_q;
    assign seq_out_valid = out_valid_q;
    assign seq_out_data  = out_data_q;
    assign seq_err       = (state_q == StErr);
    assign seq_err_code  = err_code_q;

endmodule
